regfile_rat_ckpt: RTL
=====================

Name: regfile_rat_ckpt

Overview:
- Parametrised architectural register file with a rename/alias table (busy bit + ROB tag per register).
- Has N read ports with commit bypass.
- Keeps a circular buffer of map checkpoints, so a branch mispredict restores the alias map selectively instead of clearing it.
- Sits between decode/issue (reads, rename), ROB commit (writeback) and branch resolution (checkpoint save/release/recover).

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; register 0 is hard-wired zero.
- AREG_W, 5, log2(NREG).
- TAG_W, 4, ROB tag width.
- NRD, 2, number of read ports.
- NCKPT, 4, checkpoint slots; power of two.
- CKPT_W, 2, log2(NCKPT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- rdy  in  1  global enable; low = all state frozen.
- rd_addr  in  NRD*AREG_W  read register indices; port p uses slice p.
- rd_val  out  NRD*XLEN  operand value.
- rd_ready  out  NRD  1 = value valid; 0 = wait on tag.
- rd_tag  out  NRD*TAG_W  producing ROB tag.
- commit_valid  in  1  ROB commit strobe.
- commit_dest  in  AREG_W  committed destination.
- commit_value  in  XLEN  committed value.
- commit_tag  in  TAG_W  ROB tag of the committing entry.
- rename_valid  in  1  issue renames rename_rd.
- rename_rd  in  AREG_W  destination being renamed.
- rename_tag  in  TAG_W  new ROB tag.
- ckpt_save  in  1  take a checkpoint (branch issued).
- ckpt_id  out  CKPT_W  slot that the next save uses (tail).
- ckpt_full  out  1  all slots in use.
- ckpt_release  in  1  free oldest checkpoint (branch resolved correct, in order).
- recover_valid  in  1  mispredict: restore map from recover_id.
- recover_id  in  CKPT_W  checkpoint to restore.
- flush  in  1  full pipeline flush.

Behaviour:
- Reset (rst=0, async): all regs 0, busy 0, tags 0; head/tail/count 0; ckpt_full=0; ckpt_id=0.
- Read, combinational, per port p, address a:
  - a==0: val=0, ready=1, tag=0.
  - busy[a] && commit_valid && commit_tag==tag[a]: val=commit_value, ready=1 (bypass).
  - Otherwise: val=reg[a], ready=!busy[a].
  - rd_tag=tag[a] always.
  - A same-cycle rename is not visible on the read ports.
- rdy=0: no state update; reads remain live.
- Commit (all subsequent items apply only when rdy=1):
  - commit_dest!=0: reg[dest]<=commit_value, regardless of tag.
  - If busy[dest] && tag[dest]==commit_tag, clear busy[dest].
  - The same match-and-clear is applied to every valid checkpoint slot, so snapshots never hold stale busy bits.
- Rename: rename_valid && rename_rd!=0 sets busy<=1 and tag<=rename_tag. It has priority over a commit clear of the same register in the same cycle.
- Save:
  - ckpt_save && !ckpt_full: slot[tail] <= live map after this cycle's commit and rename; tail++, count++.
  - ckpt_save while full: ignored; upstream must stall on ckpt_full.
- Release: ckpt_release && count!=0: head++, count--. Release with count==0 is ignored.
- Same-cycle save+release is legal; count is unchanged.
- Recover:
  - recover_valid: live map <= slot[recover_id] with this cycle's commit clear applied to it.
  - tail<=recover_id+1 (mod NCKPT); the restored checkpoint stays valid until released.
  - count<=recover_id-head+1 (mod NCKPT+1 arithmetic on CKPT_W+1 bits).
  - Same-cycle rename and save are dropped; a same-cycle release is honoured.
- Flush: clears all busy bits, head/tail/count. Register values are kept and the same-cycle commit still writes.
  - Priority: flush > recover > rename/save.
- ckpt_full = (count==NCKPT), registered. ckpt_id = tail.
- Tail and head wrap modulo NCKPT.
- recover_id outside the valid window is illegal; assertion only.

Test Plan:
- Reset then read x5,x0 -> val=0, ready=1 on both; ckpt_id=0, ckpt_full=0.
- Rename x3 tag 7; next cycle commit x3 tag 7 value 0xDEAD with read x3 -> same-cycle bypass ready=1 val=0xDEAD; after the edge busy=0, reg=0xDEAD.
- Rename x4 tag 2, save (slot 0), rename x4 tag 5, recover_id=0 -> x4 ready=0 tag=2; ckpt_id=1.
- Save at slot 0, commit tag 2 to x4 while it is in the snapshot, then recover 0 -> x4 ready=1, val=committed value.
- Four saves -> ckpt_full=1; fifth save ignored (ckpt_id unchanged); one release -> ckpt_full=0, save accepted at wrapped tail 0.
- Commit tag 9 to x6 that was renamed to tag 9 and re-renamed to tag 11 the same cycle -> reg[6] written, busy stays 1, tag=11; then flush -> all ready=1, values retained.

Source files
------------

// File: rtl/regfile_rat_ckpt.sv
// Architectural register file plus rename/alias table (busy bit + ROB tag per
// register) with a circular buffer of alias-map checkpoints for branch recovery.
module regfile_rat_ckpt #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AREG_W = 5,
    parameter int TAG_W  = 4,
    parameter int NRD    = 2,
    parameter int NCKPT  = 4,
    parameter int CKPT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRD*AREG_W-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_val,
    output logic [NRD-1:0]        rd_ready,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic                  commit_valid,
    input  logic [AREG_W-1:0]     commit_dest,
    input  logic [XLEN-1:0]       commit_value,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic                  rename_valid,
    input  logic [AREG_W-1:0]     rename_rd,
    input  logic [TAG_W-1:0]      rename_tag,
    input  logic                  ckpt_save,
    output logic [CKPT_W-1:0]     ckpt_id,
    output logic                  ckpt_full,
    input  logic                  ckpt_release,
    input  logic                  recover_valid,
    input  logic [CKPT_W-1:0]     recover_id,
    input  logic                  flush
);

    logic [XLEN-1:0]   reg_q   [NREG];
    logic [NREG-1:0]   busy_q, busy_d, busy_c;
    logic [TAG_W-1:0]  tag_q   [NREG];
    logic [TAG_W-1:0]  tag_d   [NREG];
    logic [NREG-1:0]   cbusy_q [NCKPT];
    logic [NREG-1:0]   cbusy_d [NCKPT];
    logic [NREG-1:0]   cbusy_c [NCKPT];
    logic [TAG_W-1:0]  ctag_q  [NCKPT][NREG];
    logic [TAG_W-1:0]  ctag_d  [NCKPT][NREG];
    logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d, rec_dist;
    logic [CKPT_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              save_acc, rel_acc, live_hit;

    assign ckpt_id   = tail_q;
    assign ckpt_full = full_q;
    assign rec_dist  = recover_id - head_q;

    // Read ports see only registered map state; commit result is bypassed.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AREG_W-1:0] a;
        logic              hit;
        assign a   = rd_addr[p*AREG_W +: AREG_W];
        assign hit = busy_q[a] && commit_valid && (commit_tag == tag_q[a]);
        assign rd_tag[p*TAG_W +: TAG_W] = (a == '0) ? '0 : tag_q[a];
        assign rd_ready[p]              = (a == '0) || hit || !busy_q[a];
        assign rd_val[p*XLEN +: XLEN]   = (a == '0) ? '0 :
                                          hit ? commit_value : reg_q[a];
    end

    assign live_hit = commit_valid && busy_q[commit_dest] &&
                      (tag_q[commit_dest] == commit_tag);

    always_comb begin
        busy_c = busy_q;
        if (live_hit) busy_c[commit_dest] = 1'b0;
        // Snapshots get the same clear so a later recover never resurrects a
        // busy bit whose producer already committed. Invalid slots are
        // overwritten before use, so clearing them too is harmless.
        for (int s = 0; s < NCKPT; s++) begin
            cbusy_c[s] = cbusy_q[s];
            if (commit_valid && cbusy_q[s][commit_dest] &&
                (ctag_q[s][commit_dest] == commit_tag))
                cbusy_c[s][commit_dest] = 1'b0;
        end

        busy_d   = busy_c;
        tag_d    = tag_q;
        cbusy_d  = cbusy_c;
        ctag_d   = ctag_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        save_acc = 1'b0;
        rel_acc  = ckpt_release && (count_q != '0);

        if (flush) begin
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (recover_valid) begin
            busy_d  = cbusy_c[recover_id];
            tag_d   = ctag_q[recover_id];
            tail_d  = recover_id + CKPT_W'(1);
            count_d = {1'b0, rec_dist} + (CKPT_W+1)'(1);
            if (rel_acc) begin
                head_d  = head_q + CKPT_W'(1);
                count_d = count_d - (CKPT_W+1)'(1);
            end
        end else begin
            if (rename_valid && (rename_rd != '0)) begin
                busy_d[rename_rd] = 1'b1;
                tag_d[rename_rd]  = rename_tag;
            end
            save_acc = ckpt_save && !full_q;
            if (save_acc) begin
                cbusy_d[tail_q] = busy_d;
                ctag_d[tail_q]  = tag_d;
                tail_d          = tail_q + CKPT_W'(1);
            end
            if (rel_acc) head_d = head_q + CKPT_W'(1);
            count_d = count_q + (CKPT_W+1)'(save_acc) - (CKPT_W+1)'(rel_acc);
        end
        full_d = (count_d == (CKPT_W+1)'(NCKPT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_q <= '{default: '0};
        end else if (rdy && commit_valid && (commit_dest != '0)) begin
            reg_q[commit_dest] <= commit_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            tag_q   <= '{default: '0};
            cbusy_q <= '{default: '0};
            ctag_q  <= '{default: '{default: '0}};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (rdy) begin
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            cbusy_q <= cbusy_d;
            ctag_q  <= ctag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Recovering to a slot outside [head, head+count) is a caller bug.
    a_recover_in_window: assert property (@(posedge clk) disable iff (!rst)
        (rdy && recover_valid && !flush) |-> ({1'b0, rec_dist} < count_q));

endmodule
